// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment bank. It walks the digits with a dark guard slot before each
// lit slot. New values pass through a pending buffer and are only copied into
// the shadow register at frame boundaries, so a refresh never shows a torn value.
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int ON_CYCLES = 50000,
    parameter int GUARD     = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  ack,
    output logic [3:0]            dec_in,
    output logic [DIGITS-1:0]     an_n,
    output logic                  dp_n
);

    localparam int MAX_A = (ON_CYCLES > GUARD) ? ON_CYCLES : GUARD;
    localparam int MAX_C = (MAX_A > 2) ? MAX_A : 2;
    localparam int CW    = $clog2(MAX_C);
    localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = (GUARD > 0) ? CW'(GUARD - 1) : '0;
    localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);

    typedef enum logic {
        PH_GUARD = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

    // With no guard interval the controller never enters the dark phase.
    localparam phase_t PH_START = (GUARD == 0) ? PH_ON : PH_GUARD;
    localparam phase_t PH_AFTER = (GUARD == 0) ? PH_ON : PH_GUARD;

    phase_t            phase, phase_nx;
    logic [DW-1:0]     digit, digit_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              frame_end;

    logic [4*DIGITS-1:0] pend_data, shadow_data;
    logic [DIGITS-1:0]   pend_blank, shadow_blank;
    logic [DIGITS-1:0]   pend_dp, shadow_dp;
    logic                pend;
    logic                ack_q;

    // Scan state register: phase, digit index and slot cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_START;
            digit <= '0;
            cnt   <= '0;
        end else begin
            phase <= phase_nx;
            digit <= digit_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic for the scan; flags the edge leaving the last digit's ON slot.
    always_comb begin
        phase_nx  = phase;
        digit_nx  = digit;
        cnt_nx    = cnt + 1'b1;
        frame_end = 1'b0;
        case (phase)
            PH_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    phase_nx = PH_ON;
                    cnt_nx   = '0;
                end
            end
            PH_ON: begin
                if (cnt == ON_LAST) begin
                    phase_nx = PH_AFTER;
                    cnt_nx   = '0;
                    if (digit == DIG_LAST) begin
                        digit_nx  = '0;
                        frame_end = 1'b1;
                    end else begin
                        digit_nx = digit + 1'b1;
                    end
                end
            end
            default: begin
                phase_nx = PH_START;
                cnt_nx   = '0;
            end
        endcase
    end

    // Load handshake: capture into pending, promote to shadow at frame boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data    <= '0;
            pend_blank   <= '1;
            pend_dp      <= '0;
            pend         <= 1'b0;
            shadow_data  <= '0;
            shadow_blank <= '1;
            shadow_dp    <= '0;
            ack_q        <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (frame_end && pend) begin
                shadow_data  <= pend_data;
                shadow_blank <= pend_blank;
                shadow_dp    <= pend_dp;
                ack_q        <= 1'b1;
            end
            if (load) begin
                pend_data  <= data_in;
                pend_blank <= blank_mask;
                pend_dp    <= dp_mask;
                pend       <= 1'b1;
            end else if (frame_end && pend) begin
                pend <= 1'b0;
            end
        end
    end

    // Display outputs decoded purely from registered state.
    always_comb begin
        dec_in = shadow_data[{digit, 2'b00} +: 4];
        an_n   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (phase == PH_ON && digit == DW'(i) && !shadow_blank[i]) begin
                an_n[i] = 1'b0;
            end
        end
        dp_n = !(phase == PH_ON && shadow_dp[digit]);
    end

    assign ack = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with DIGITS=4,
// ON_CYCLES=4, GUARD=1 (20-cycle frames). Stimulus pushes hand-computed ack
// edges and lit-slot records; a monitor pops them when the DUT presents them.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
    logic        ack;
    logic [3:0]  dec_in;
    logic [3:0]  an_n;
    logic        dp_n;

    typedef struct {
        int         start;
        logic [3:0] an;
        logic [3:0] dec;
        logic       dp;
    } lit_t;

    lit_t lit_q[$];
    int   ack_q[$];
    int   edge_cnt;
    int   total;
    int   bad;

    seg_scan_ctrl #(
        .DIGITS(4),
        .ON_CYCLES(4),
        .GUARD(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .data_in(data_in),
        .blank_mask(blank_mask),
        .dp_mask(dp_mask),
        .ack(ack),
        .dec_in(dec_in),
        .an_n(an_n),
        .dp_n(dp_n)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter since reset release; edge n is the n-th rising edge after release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Queue the lit slots of one frame starting at boundary edge 'base'.
    task automatic expectFrame(input int base, input logic [15:0] nib,
                               input logic [3:0] blank, input logic [3:0] dp);
        lit_t r;
        for (int i = 0; i < 4; i++) begin
            if (!blank[i]) begin
                r.start = base + 5 * i + 1;
                r.an    = 4'hF;
                r.an[i] = 1'b0;
                r.dec   = nib[4*i +: 4];
                r.dp    = ~dp[i];
                lit_q.push_back(r);
            end
        end
    endtask

    task automatic waitEdge(input int n);
        int guard_cnt;
        guard_cnt = 0;
        while (edge_cnt != n) begin
            @(negedge clk);
            guard_cnt++;
            if (guard_cnt > 300) begin
                total++;
                bad++;
                $display("[TB] FAIL wait_edge: got edge %0d expected edge %0d", edge_cnt, n);
                return;
            end
        end
    endtask

    // Present a one-cycle load that the DUT samples on rising edge 'at_edge'.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] b,
                                 input logic [3:0] p, input int at_edge);
        waitEdge(at_edge - 1);
        load       = 1'b1;
        data_in    = d;
        blank_mask = b;
        dp_mask    = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic checkReset();
        checkOutput("rst_an_n", int'(an_n), 32'hF);
        checkOutput("rst_dp_n", int'(dp_n), 1);
        checkOutput("rst_ack",  int'(ack), 0);
        checkOutput("rst_dec",  int'(dec_in), 0);
    endtask

    // Monitor: pops ack and lit-slot expectations as the DUT presents them.
    initial begin : monitor
        logic       prev_lit;
        logic       lit;
        int         run_len;
        logic [3:0] cur_an;
        logic [3:0] cur_dec;
        lit_t       r;
        prev_lit = 1'b0;
        run_len  = 0;
        cur_an   = 4'hF;
        cur_dec  = 4'h0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                prev_lit = 1'b0;
                run_len  = 0;
            end else begin
                lit = (an_n != 4'hF);
                if (ack) begin
                    if (ack_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_ack: got ack=1 expected ack=0 (edge %0d)", edge_cnt);
                    end else begin
                        checkOutput("ack_edge", edge_cnt, ack_q.pop_front());
                    end
                end
                if (lit) begin
                    checkOutput("one_anode", $countones(~an_n), 1);
                end
                if (lit && !prev_lit) begin
                    if (lit_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_lit: got an_n=%b expected 1111 (edge %0d)", an_n, edge_cnt);
                    end else begin
                        r = lit_q.pop_front();
                        checkOutput("slot_start", edge_cnt, r.start);
                        checkOutput("slot_an_n", int'(an_n), int'(r.an));
                        checkOutput("slot_dec", int'(dec_in), int'(r.dec));
                        checkOutput("slot_dp_n", int'(dp_n), int'(r.dp));
                    end
                    cur_an  = an_n;
                    cur_dec = dec_in;
                    run_len = 1;
                end else if (lit) begin
                    checkOutput("hold_an_n", int'(an_n), int'(cur_an));
                    checkOutput("hold_dec", int'(dec_in), int'(cur_dec));
                    run_len++;
                end else begin
                    if (prev_lit) checkOutput("slot_len", run_len, 4);
                    checkOutput("dark_dp_n", int'(dp_n), 1);
                end
                prev_lit = lit;
            end
        end
    end

    // Directed stimulus sequence.
    initial begin : stimulus
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        load       = 1'b0;
        data_in    = 16'h0;
        blank_mask = 4'h0;
        dp_mask    = 4'h0;

        repeat (3) @(negedge clk);
        checkReset();
        rst_n = 1'b1;

        waitEdge(3);
        checkOutput("idle_dec", int'(dec_in), 0);
        checkOutput("idle_an_n", int'(an_n), 32'hF);

        // Basic scan: applied at boundary edge 20.
        ack_q.push_back(20);
        expectFrame(20, 16'h1234, 4'b0000, 4'b0100);
        applyStimulus(16'h1234, 4'b0000, 4'b0100, 5);

        // No tearing, latest wins: both loads inside frame 1, one ack at 40.
        applyStimulus(16'hAAAA, 4'b0000, 4'b0000, 28);
        ack_q.push_back(40);
        expectFrame(40, 16'h5555, 4'b0000, 4'b0000);
        applyStimulus(16'h5555, 4'b0000, 4'b0000, 30);

        // Boundary collision: 1111 pending, 2222 loaded on boundary edge 60.
        ack_q.push_back(60);
        expectFrame(60, 16'h1111, 4'b0000, 4'b0000);
        applyStimulus(16'h1111, 4'b0000, 4'b0000, 45);
        ack_q.push_back(80);
        expectFrame(80, 16'h2222, 4'b0000, 4'b0000);
        applyStimulus(16'h2222, 4'b0000, 4'b0000, 60);

        // Blanking: digits 1 and 3 stay dark, value persists into frame 6.
        ack_q.push_back(100);
        expectFrame(100, 16'h9876, 4'b1010, 4'b0001);
        expectFrame(120, 16'h9876, 4'b1010, 4'b0001);
        applyStimulus(16'h9876, 4'b1010, 4'b0001, 85);

        // Reset during ON of digit 2 with a load pending.
        applyStimulus(16'h4321, 4'b0000, 4'b0000, 125);
        waitEdge(133);
        rst_n = 1'b0;
        #1;
        checkReset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        waitEdge(45);
        checkReset();

        checkOutput("lit_q_left", lit_q.size(), 0);
        checkOutput("ack_q_left", ack_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for a common-anode seven-segment display bank. It stores a multi-digit hex value in a shadow register and steps through the digits. For each digit it drives the 4-bit nibble to the hex-to-segment decoder and enables one active-low anode, with a dark guard interval between digits to suppress ghosting. New values are accepted through a load/ack handshake and applied only at frame boundaries, so a refresh never shows a torn value.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned; must be ≥ 1.
- ON_CYCLES, 50000: clock cycles each digit is lit; must be ≥ 1.
- GUARD, 500: dark clock cycles before each digit; ≥ 0, and 0 removes the guard phase.

Ports:
- clk  in  1  system clock; everything is updated on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle request to capture data_in, blank_mask and dp_mask.
- data_in  in  4*DIGITS  digit i is data_in[4i+3:4i]; digit 0 is the rightmost digit.
- blank_mask  in  DIGITS  bit i = 1 keeps digit i dark.
- dp_mask  in  DIGITS  bit i = 1 lights the decimal point of digit i.
- ack  out  1  one-cycle pulse when pending data is copied into the shadow register.
- dec_in  out  4  nibble driven to the hex-to-segment decoder.
- an_n  out  DIGITS  active-low anode enables.
- dp_n  out  1  active-low decimal-point segment.

## Operation
Registered state:
- phase: GUARD or ON.
- digit index: 0..DIGITS-1.
- cycle counter: width $clog2(max(ON_CYCLES,GUARD,2)).
- pending registers: data, blank and dp, plus a pend flag.
- shadow registers: data, blank and dp.
- ack register.

Reset (rst_n low, asynchronous):
- phase = GUARD, or ON when GUARD = 0.
- digit = 0, counter = 0, pend = 0, ack = 0.
- Shadow data = 0, shadow blank = all ones, shadow dp = 0.
- Resulting outputs: an_n all ones, dp_n = 1, dec_in = 0, ack = 0.
- Reset mid-frame aborts the scan immediately. Any pending load is discarded and not acknowledged.

Scan sequencing, on each clock edge:
- In GUARD: if counter == GUARD-1, go to ON and clear the counter; otherwise increment the counter.
- In ON: if counter == ON_CYCLES-1, go to GUARD (or directly to ON when GUARD = 0), advance digit (DIGITS-1 wraps to 0) and clear the counter; otherwise increment the counter.
- The frame boundary is the edge that leaves ON of digit DIGITS-1.

Outputs are decoded only from registered state and never depend combinationally on the inputs:
- dec_in = shadow nibble of the current digit, in both phases.
- an_n[i] = 0 only when phase = ON, digit = i and shadow blank[i] = 0. All other anode bits are 1.
- dp_n = 0 only when phase = ON and shadow dp[current digit] = 1.

Load handshake:
- A load edge copies the inputs into the pending registers and sets pend.
- A second load while pend is set overwrites the pending value (latest wins). Only one ack is issued for it.
- At a frame boundary with pend = 1: shadow takes the pending value, pend clears, and ack = 1 for the following cycle only.
- load on the same edge as a frame-boundary latch:
  - the older pending value goes to shadow and ack fires;
  - the new value goes to pending, pend stays 1, and it is applied at the next boundary.
- load with pend = 0 exactly at a frame boundary is not applied on that boundary. It waits for the next one.

## Timing
- Slot length per digit is GUARD + ON_CYCLES cycles. Frame length is DIGITS × (GUARD + ON_CYCLES) cycles.
- Load-to-display latency:
  - minimum 1 cycle, plus GUARD cycles before the first lit digit;
  - maximum one full frame plus 1 cycle.
- ack is asserted in the first cycle of digit 0's GUARD phase (or ON phase when GUARD = 0) of the new frame.
- an_n never has more than one bit low at a time.
- During GUARD, all anodes are high (an_n all ones).

## Test plan
All scenarios use DIGITS=4, ON_CYCLES=4, GUARD=1, so a frame is 20 cycles.
- **Reset defaults:** hold rst_n low, then release -> an_n = 4'b1111, dp_n = 1, ack = 0 at all times. The scan still runs, so dec_in = 0 throughout.
- **Basic scan:** load data_in = 16'h1234, blank_mask = 0, dp_mask = 4'b0100 -> ack pulses at the next boundary. Each 5-cycle slot is then 1 dark cycle followed by 4 lit cycles, in this order:
  - an_n = 1110 with dec_in = 4;
  - an_n = 1101 with dec_in = 3;
  - an_n = 1011 with dec_in = 2 and dp_n = 0;
  - an_n = 0111 with dec_in = 1.
- **No tearing, latest wins:** load 16'hAAAA in the middle of digit 1, then load 16'h5555 two cycles later -> the current frame still shows the old value, exactly one ack occurs, and the next frame shows 5555.
- **Boundary collision:** with 16'h1111 pending, load 16'h2222 on the boundary edge -> ack fires and the next frame shows 1111. A second ack fires 20 cycles later and 2222 is displayed from then on.
- **Blanking:** blank_mask = 4'b1010 -> an_n[1] and an_n[3] never go low. Slot timing is unchanged.
- **Reset mid-operation:** assert rst_n during ON of digit 2 with a load pending -> outputs reach their reset values immediately, and no ack follows after release.
